fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage feeding decode's instr input. Holds PC, requests words from a
//  variable-latency instruction memory, and presents instr/PC+2 to decode with valid/stall flow
//  control. Supports redirect (branch/jump) with squash, HALT detection, and timeout/alignment errors.
// PARAMETERS
//  RESET_PC    16'h0000  PC loaded on reset
//  WAIT_LIMIT  255       max cycles in REQ without imem_done before error
// PORTS
//  clk          in   1   clock
//  rst          in   1   asynchronous reset, active-high
//  imem_rd      out  1   read request, held high until imem_done
//  imem_addr    out  16  read address (= pc while imem_rd)
//  imem_data    in   16  instruction word, valid with imem_done
//  imem_done    in   1   read completes this cycle (may coincide with first imem_rd cycle)
//  id_instr     out  16  instruction to decode
//  id_pc_inc    out  16  PC+2 of id_instr
//  id_valid     out  1   id_instr/id_pc_inc valid
//  id_stall     in   1   decode holds current instr; consumed when id_valid & !id_stall
//  redirect     in   1   one-cycle pulse: flush and refetch from redirect_pc
//  redirect_pc  in   16  new PC target
//  halted       out  1   HALT delivered; fetch stopped
//  err          out  1   sticky error; cleared only by rst
// BEHAVIOUR
//  - Reset (async): pc=RESET_PC, state=REQ, id_valid=0, id_instr=16'h0800 (NOP), id_pc_inc=0,
//    skid empty, squash=0, wait_cnt=0, halted=0, err=0. imem_rd is 0 during reset, 1 in first cycle after.
//  - States: REQ, HOLD, HALTED, ERR. imem_rd=1 only in REQ.
//  - REQ, done, no squash: pc<=pc+2 (mod 2^16, 16'hFFFE->16'h0000); word goes to id regs if
//    !id_valid|!id_stall, else into skid and ->HOLD. Opcode imem_data[15:11]==5'b00000 (HALT):
//    word delivered normally, then ->HALTED (no further requests; halted=1 once HALT is in id regs).
//  - Latency: imem_done in cycle N -> id_valid=1 with that word in cycle N+1.
//  - HOLD: no request. When !id_stall, skid->id regs, skid cleared, ->REQ (or HALTED if skid was HALT).
//  - Consumed with no new word that cycle -> id_valid<=0; id regs keep last values.
//  - Redirect (any state except ERR) has priority over all else: next cycle id_valid=0 (ignores id_stall),
//    skid cleared, halted=0, pc<=redirect_pc, wait_cnt=0.
//    In REQ without same-cycle done: set squash, stay REQ holding old address; on done, discard word,
//    clear squash, next cycle issue at new pc. Done same cycle as redirect: word discarded, next
//    cycle REQ at redirect_pc. Second redirect while squash set: pc updated, squash stays set.
//  - redirect_pc[0]=1: err<=1, ->ERR. Timeout: wait_cnt increments each REQ cycle without done;
//    reaching WAIT_LIMIT sets err and ->ERR. ERR: imem_rd=0, id_valid=0, ignores all inputs until rst.
//  - Reset mid-request: all outputs return to reset values immediately; late imem_done ignored.
// STRUCTURE
//  - Shared package: opcode constants (HALT 5'b00000, NOP 5'b00001), NOP_INSTR 16'h0800,
//    fetch state encoding (2 bits), instruction/PC width (16).
//  - One sub-module: ifid_skid (one-entry buffer, instr+pc_inc, load/unload/clear).
//    PC adder and FSM remain in fetch_stage.
// TESTING
//  1. Reset, zero-wait memory (done with rd) -> imem_addr 0,2,4,..; id_valid from cycle 2; id_pc_inc 2,4,6.
//  2. id_stall high 3 cycles with 1-cycle memory -> id_instr frozen, one word in skid, no request;
//     release -> words in order, none lost or duplicated.
//  3. Redirect to 16'h0100 during 3-cycle memory wait -> returned word dropped, id_valid=0 next cycle,
//     next imem_addr=16'h0100, first delivered id_pc_inc=16'h0102.
//  4. Word 16'h0000 at 16'h0006 -> delivered, halted=1, imem_rd=0 thereafter; redirect to 16'h0010
//     -> halted=0, fetch resumes at 16'h0010.
//  5. Memory never asserts done -> err=1 after WAIT_LIMIT cycles, imem_rd=0; rst clears err.
//  6. Redirect to 16'h0011 -> err=1, ERR state; async rst asserted mid-wait -> outputs reset same cycle.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, opcodes, FSM encoding, IF/ID entry.
package fetch_stage_pkg;

    localparam int INSTR_W = 16;
    localparam int PC_W    = 16;

    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_NOP  = 5'b00001;

    localparam logic [INSTR_W-1:0] NOP_INSTR = {OP_NOP, 11'b0};

    typedef enum logic [1:0] {
        ST_REQ    = 2'd0,
        ST_HOLD   = 2'd1,
        ST_HALTED = 2'd2,
        ST_ERR    = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc_inc;
    } ifid_entry_t;

    // Top five bits carry the opcode; all-zero opcode stops the fetch stream.
    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: 5] == OP_HALT;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of instruction-memory, decode-side and control signals around the fetch stage.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic               imem_rd;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               imem_done;
    logic [INSTR_W-1:0] id_instr;
    logic [PC_W-1:0]    id_pc_inc;
    logic               id_valid;
    logic               id_stall;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic               halted;
    logic               err;

    // Fetch stage side.
    modport master (
        output imem_rd, imem_addr,
        input  imem_data, imem_done,
        output id_instr, id_pc_inc, id_valid,
        input  id_stall, redirect, redirect_pc,
        output halted, err
    );

    // Memory / decode / control side.
    modport slave (
        input  imem_rd, imem_addr,
        output imem_data, imem_done,
        input  id_instr, id_pc_inc, id_valid,
        output id_stall, redirect, redirect_pc,
        input  halted, err
    );
endinterface

// File: rtl/fetch_stage_ifid_skid.sv
// One-entry buffer catching a fetched word that decode cannot accept yet.
module ifid_skid
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        unload,
    input  logic        clear,
    input  ifid_entry_t din,
    output logic        full,
    output ifid_entry_t dout
);

    logic        full_reg;
    ifid_entry_t data_reg;

    // Clear wins over load, load over unload; data is only meaningful while full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_reg <= 1'b0;
            data_reg <= '0;
        end else if (clear) begin
            full_reg <= 1'b0;
        end else if (load) begin
            full_reg <= 1'b1;
            data_reg <= din;
        end else if (unload) begin
            full_reg <= 1'b0;
        end
    end

    assign full = full_reg;
    assign dout = data_reg;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, variable-latency memory requests, IF/ID register with skid, redirect/squash, HALT and error handling.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = 16'h0000,
    parameter int              WAIT_LIMIT = 255
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    localparam int              CNT_W    = $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

    fetch_state_t       state_reg;
    logic [PC_W-1:0]    pc_reg;
    logic               squash_reg;
    logic [PC_W-1:0]    squash_addr_reg;
    logic [CNT_W-1:0]   wait_cnt_reg;
    logic [INSTR_W-1:0] id_instr_reg;
    logic [PC_W-1:0]    id_pc_inc_reg;
    logic               id_valid_reg;
    logic               halted_reg;
    logic               err_reg;

    logic [PC_W-1:0] pc_plus2;
    logic            consume;
    logic            accept;
    logic            fetch_ok;
    logic            skid_load;
    logic            skid_unload;
    logic            skid_clear;
    logic            skid_full;
    ifid_entry_t     fetched_entry;
    ifid_entry_t     skid_entry;

    assign pc_plus2      = pc_reg + PC_W'(2);
    assign consume       = id_valid_reg & ~bus.id_stall;
    assign accept        = ~id_valid_reg | ~bus.id_stall;
    assign fetch_ok      = (state_reg == ST_REQ) & bus.imem_done & ~squash_reg & ~bus.redirect;
    assign fetched_entry = {bus.imem_data, pc_plus2};

    assign skid_load   = fetch_ok & ~accept;
    assign skid_unload = (state_reg == ST_HOLD) & skid_full & ~bus.id_stall & ~bus.redirect;
    assign skid_clear  = bus.redirect & (state_reg != ST_ERR);

    ifid_skid u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_load),
        .unload (skid_unload),
        .clear  (skid_clear),
        .din    (fetched_entry),
        .full   (skid_full),
        .dout   (skid_entry)
    );

    // Fetch FSM with PC, squash tracking, timeout counter and IF/ID output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_REQ;
            pc_reg          <= RESET_PC;
            squash_reg      <= 1'b0;
            squash_addr_reg <= '0;
            wait_cnt_reg    <= '0;
            id_instr_reg    <= NOP_INSTR;
            id_pc_inc_reg   <= '0;
            id_valid_reg    <= 1'b0;
            halted_reg      <= 1'b0;
            err_reg         <= 1'b0;
        end else if (state_reg != ST_ERR) begin
            if (bus.redirect) begin
                // Redirect flushes decode's view regardless of stall.
                id_valid_reg <= 1'b0;
                halted_reg   <= 1'b0;
                wait_cnt_reg <= '0;
                pc_reg       <= bus.redirect_pc;
                if (bus.redirect_pc[0]) begin
                    err_reg   <= 1'b1;
                    state_reg <= ST_ERR;
                end else begin
                    state_reg <= ST_REQ;
                    if (state_reg == ST_REQ && !bus.imem_done) begin
                        // The outstanding read must still finish at its original address.
                        squash_reg <= 1'b1;
                        if (!squash_reg) begin
                            squash_addr_reg <= pc_reg;
                        end
                    end else begin
                        squash_reg <= 1'b0;
                    end
                end
            end else begin
                case (state_reg)
                    ST_REQ: begin
                        if (bus.imem_done) begin
                            wait_cnt_reg <= '0;
                            if (squash_reg) begin
                                squash_reg <= 1'b0;
                                if (consume) begin
                                    id_valid_reg <= 1'b0;
                                end
                            end else begin
                                pc_reg <= pc_plus2;
                                if (accept) begin
                                    id_instr_reg  <= bus.imem_data;
                                    id_pc_inc_reg <= pc_plus2;
                                    id_valid_reg  <= 1'b1;
                                    if (is_halt(bus.imem_data)) begin
                                        state_reg  <= ST_HALTED;
                                        halted_reg <= 1'b1;
                                    end
                                end else begin
                                    state_reg <= ST_HOLD;
                                end
                            end
                        end else begin
                            if (consume) begin
                                id_valid_reg <= 1'b0;
                            end
                            if (wait_cnt_reg == CNT_LAST) begin
                                err_reg      <= 1'b1;
                                id_valid_reg <= 1'b0;
                                state_reg    <= ST_ERR;
                            end else begin
                                wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (skid_unload) begin
                            id_instr_reg  <= skid_entry.instr;
                            id_pc_inc_reg <= skid_entry.pc_inc;
                            id_valid_reg  <= 1'b1;
                            if (is_halt(skid_entry.instr)) begin
                                state_reg  <= ST_HALTED;
                                halted_reg <= 1'b1;
                            end else begin
                                state_reg <= ST_REQ;
                            end
                        end
                    end
                    ST_HALTED: begin
                        if (consume) begin
                            id_valid_reg <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Request is suppressed while reset is held so memory never sees a stray read.
    assign bus.imem_rd   = (state_reg == ST_REQ) & ~rst;
    assign bus.imem_addr = squash_reg ? squash_addr_reg : pc_reg;
    assign bus.id_instr  = id_instr_reg;
    assign bus.id_pc_inc = id_pc_inc_reg;
    assign bus.id_valid  = id_valid_reg;
    assign bus.halted    = halted_reg;
    assign bus.err       = err_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: behavioural memory with configurable latency and an in-order program model.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam int WAIT_LIMIT = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_stage_if bus();

    fetch_stage #(
        .RESET_PC   (16'h0000),
        .WAIT_LIMIT (WAIT_LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:255];
    int          mem_lat;
    int          mem_cnt;
    int          n_done;
    int          n_checks;
    int          n_fail;
    int          n_consumed;
    logic [15:0] exp_pc;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return mem[a[8:1]];
    endfunction

    // Memory responder: decides done/data at each falling edge; n_done counts completed cycles with done.
    initial begin
        bus.imem_done = 1'b0;
        bus.imem_data = 16'h0;
        mem_cnt = 0;
        n_done  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                n_done = 0;
                mem_cnt = 0;
                bus.imem_done = 1'b0;
            end else begin
                if (bus.imem_done) n_done++;
                if (bus.imem_rd) begin
                    if (mem_cnt >= mem_lat) begin
                        bus.imem_done = 1'b1;
                        bus.imem_data = mem_word(bus.imem_addr);
                        mem_cnt = 0;
                    end else begin
                        bus.imem_done = 1'b0;
                        bus.imem_data = 16'($urandom);
                        mem_cnt++;
                    end
                end else begin
                    bus.imem_done = 1'b0;
                    mem_cnt = 0;
                end
            end
        end
    end

    task automatic fill_mem();
        logic [15:0] w;
        for (int i = 0; i < 256; i++) begin
            w = 16'($urandom);
            if (w[15:11] == 5'b00000) w[15:11] = 5'b10101;
            mem[i] = w;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.redirect = 1'b0;
        bus.id_stall = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_pc = 16'h0000;
        n_consumed = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_lat = 0;
        bus.id_stall = 1'b0;
        bus.redirect = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_id_valid: got %b expected 0", bus.id_valid); end
        n_checks++; if (bus.id_instr !== 16'h0800) begin n_fail++; $display("FAIL reset_id_instr: got %h expected 0800", bus.id_instr); end
        n_checks++; if (bus.id_pc_inc !== 16'h0000) begin n_fail++; $display("FAIL reset_id_pc_inc: got %h expected 0000", bus.id_pc_inc); end
        n_checks++; if (bus.imem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_imem_rd: got %b expected 0", bus.imem_rd); end
        n_checks++; if ({bus.halted, bus.err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b expected 00", {bus.halted, bus.err}); end
        @(posedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            n_checks++; if (bus.imem_rd !== 1'b1 || bus.imem_addr !== 16'(2 * k)) begin
                n_fail++; $display("FAIL zw_addr: cycle %0d got rd=%b addr=%h expected rd=1 addr=%h", k, bus.imem_rd, bus.imem_addr, 16'(2 * k));
            end
            n_checks++; if (bus.id_valid !== (k > 0)) begin n_fail++; $display("FAIL zw_valid: cycle %0d got %b expected %b", k, bus.id_valid, (k > 0)); end
            if (k > 0) begin
                n_checks++; if (bus.id_pc_inc !== 16'(2 * k) || bus.id_instr !== mem_word(16'(2 * k - 2))) begin
                    n_fail++; $display("FAIL zw_word: cycle %0d got %h/%h expected %h/%h", k, bus.id_instr, bus.id_pc_inc, mem_word(16'(2 * k - 2)), 16'(2 * k));
                end
            end
        end
        $display("test_reset: zero-wait stream of 7 words checked");
    endtask

    task automatic test_stall_skid();
        int          held;
        bit          last_stalled;
        logic [15:0] last_instr;
        do_reset();
        mem_lat = 0;
        last_stalled = 1'b0;
        last_instr = 16'h0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk); #1;
            if (c < 4 || (c >= 7 && c < 9)) bus.id_stall = 1'b0;
            else if (c < 7) bus.id_stall = 1'b1;
            else bus.id_stall = ($urandom_range(2) == 0);
            held = n_done - n_consumed;
            n_checks++; if (held > 2 || held < 0) begin n_fail++; $display("FAIL occupancy: cycle %0d got %0d words held expected 0..2", c, held); end
            n_checks++; if (bus.id_valid !== (held > 0)) begin n_fail++; $display("FAIL stall_valid: cycle %0d got %b expected %b", c, bus.id_valid, (held > 0)); end
            if (held >= 2) begin
                n_checks++; if (bus.imem_rd !== 1'b0) begin n_fail++; $display("FAIL full_no_req: cycle %0d got rd=%b expected 0", c, bus.imem_rd); end
            end
            if (last_stalled) begin
                n_checks++; if (bus.id_instr !== last_instr) begin n_fail++; $display("FAIL frozen: cycle %0d got %h expected %h", c, bus.id_instr, last_instr); end
            end
            if (bus.id_valid && !bus.id_stall) begin
                n_checks++; if (bus.id_instr !== mem_word(exp_pc) || bus.id_pc_inc !== exp_pc + 16'd2) begin
                    n_fail++; $display("FAIL stall_order: got %h/%h expected %h/%h", bus.id_instr, bus.id_pc_inc, mem_word(exp_pc), exp_pc + 16'd2);
                end
                exp_pc = exp_pc + 16'd2;
                n_consumed++;
            end
            last_stalled = bus.id_valid && bus.id_stall;
            last_instr = bus.id_instr;
        end
        n_checks++; if (n_consumed < 20) begin n_fail++; $display("FAIL stall_progress: got %0d words expected at least 20", n_consumed); end
        $display("test_stall_skid: %0d words delivered in order", n_consumed);
    endtask

    task automatic test_redirect();
        bit          seen;
        bit          prev_redir;
        logic [15:0] tgt;
        do_reset();
        mem_lat = 2;
        @(negedge clk); #1;
        @(negedge clk); #1;
        bus.redirect = 1'b1;
        bus.redirect_pc = 16'h0100;
        exp_pc = 16'h0100;
        @(negedge clk); #1;
        bus.redirect = 1'b0;
        n_checks++; if (bus.id_valid !== 1'b0 || bus.imem_rd !== 1'b1 || bus.imem_addr !== 16'h0000) begin
            n_fail++; $display("FAIL squash_hold: got valid=%b rd=%b addr=%h expected 0/1/0000", bus.id_valid, bus.imem_rd, bus.imem_addr);
        end
        @(negedge clk); #1;
        n_checks++; if (bus.imem_addr !== 16'h0100 || bus.id_valid !== 1'b0) begin
            n_fail++; $display("FAIL redirect_addr: got addr=%h valid=%b expected 0100/0", bus.imem_addr, bus.id_valid);
        end
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk); #1;
            if (bus.id_valid) seen = 1'b1;
        end
        n_checks++; if (!seen || bus.id_pc_inc !== 16'h0102 || bus.id_instr !== mem_word(16'h0100)) begin
            n_fail++; $display("FAIL redirect_first: got seen=%b %h/%h expected %h/0102", seen, bus.id_instr, bus.id_pc_inc, mem_word(16'h0100));
        end
        // Random phase: stalls, variable latency and redirects against the in-order model.
        prev_redir = 1'b0;
        for (int c = 0; c < 200; c++) begin
            mem_lat = $urandom_range(2);
            bus.id_stall = ($urandom_range(3) == 0);
            if (prev_redir) begin
                n_checks++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL redirect_flush: cycle %0d got valid=%b expected 0", c, bus.id_valid); end
            end
            if ($urandom_range(7) == 0) begin
                tgt = 16'($urandom_range(200) * 2);
                bus.redirect = 1'b1;
                bus.redirect_pc = tgt;
                exp_pc = tgt;
                prev_redir = 1'b1;
            end else begin
                bus.redirect = 1'b0;
                prev_redir = 1'b0;
                if (bus.id_valid && !bus.id_stall) begin
                    n_checks++; if (bus.id_instr !== mem_word(exp_pc) || bus.id_pc_inc !== exp_pc + 16'd2) begin
                        n_fail++; $display("FAIL redirect_order: got %h/%h expected %h/%h", bus.id_instr, bus.id_pc_inc, mem_word(exp_pc), exp_pc + 16'd2);
                    end
                    exp_pc = exp_pc + 16'd2;
                end
            end
            @(negedge clk); #1;
        end
        bus.redirect = 1'b0;
        $display("test_redirect: squash and random redirect stream checked");
    endtask

    task automatic test_halt(input bit rand_stall);
        bit seen;
        do_reset();
        mem_lat = 0;
        mem[3] = 16'h0000;
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk); #1;
            if (bus.halted) begin
                seen = 1'b1;
                bus.id_stall = 1'b0;
                n_checks++; if (bus.id_valid !== 1'b1 || bus.id_instr !== 16'h0000 || bus.id_pc_inc !== 16'h0008 || exp_pc !== 16'h0006) begin
                    n_fail++; $display("FAIL halt_word: got valid=%b %h/%h model_pc=%h expected 1 0000/0008 0006", bus.id_valid, bus.id_instr, bus.id_pc_inc, exp_pc);
                end
            end else begin
                bus.id_stall = rand_stall ? ($urandom_range(1) == 0) : 1'b0;
                if (bus.id_valid && !bus.id_stall) begin
                    n_checks++; if (bus.id_instr !== mem_word(exp_pc) || bus.id_pc_inc !== exp_pc + 16'd2) begin
                        n_fail++; $display("FAIL halt_order: got %h/%h expected %h/%h", bus.id_instr, bus.id_pc_inc, mem_word(exp_pc), exp_pc + 16'd2);
                    end
                    exp_pc = exp_pc + 16'd2;
                end
            end
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL halt_timeout: halted=%b expected 1 within 60 cycles", bus.halted); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            n_checks++; if (bus.imem_rd !== 1'b0 || bus.halted !== 1'b1 || bus.id_valid !== 1'b0) begin
                n_fail++; $display("FAIL halt_idle: got rd=%b halted=%b valid=%b expected 0/1/0", bus.imem_rd, bus.halted, bus.id_valid);
            end
        end
        bus.redirect = 1'b1;
        bus.redirect_pc = 16'h0010;
        @(negedge clk); #1;
        bus.redirect = 1'b0;
        n_checks++; if (bus.halted !== 1'b0 || bus.imem_rd !== 1'b1 || bus.imem_addr !== 16'h0010) begin
            n_fail++; $display("FAIL halt_resume: got halted=%b rd=%b addr=%h expected 0/1/0010", bus.halted, bus.imem_rd, bus.imem_addr);
        end
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk); #1;
            if (bus.id_valid) seen = 1'b1;
        end
        n_checks++; if (!seen || bus.id_pc_inc !== 16'h0012 || bus.id_instr !== mem_word(16'h0010)) begin
            n_fail++; $display("FAIL halt_refetch: got seen=%b %h/%h expected %h/0012", seen, bus.id_instr, bus.id_pc_inc, mem_word(16'h0010));
        end
        mem[3] = 16'h5a5a;
        $display("test_halt: stall mode %0d, HALT delivered and fetch resumed", rand_stall);
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        mem_lat = 1000000;
        n = 0;
        for (int c = 1; c <= 400 && n == 0; c++) begin
            @(negedge clk); #1;
            if (bus.err) n = c;
        end
        n_checks++; if (n != WAIT_LIMIT + 1) begin n_fail++; $display("FAIL timeout_cycle: err first seen at cycle %0d expected %0d", n, WAIT_LIMIT + 1); end
        n_checks++; if (bus.imem_rd !== 1'b0 || bus.id_valid !== 1'b0) begin
            n_fail++; $display("FAIL timeout_idle: got rd=%b valid=%b expected 0/0", bus.imem_rd, bus.id_valid);
        end
        rst = 1'b1;
        #1;
        n_checks++; if (bus.err !== 1'b0 || bus.imem_rd !== 1'b0) begin
            n_fail++; $display("FAIL timeout_rst: got err=%b rd=%b expected 0/0", bus.err, bus.imem_rd);
        end
        mem_lat = 0;
        do_reset();
        $display("test_timeout: err after %0d cycles without done", n);
    endtask

    task automatic test_err_async_reset();
        bit seen;
        do_reset();
        mem_lat = 0;
        repeat (3) begin @(negedge clk); #1; end
        bus.redirect = 1'b1;
        bus.redirect_pc = 16'h0011;
        @(negedge clk); #1;
        bus.redirect = 1'b0;
        n_checks++; if (bus.err !== 1'b1 || bus.imem_rd !== 1'b0 || bus.id_valid !== 1'b0) begin
            n_fail++; $display("FAIL misalign: got err=%b rd=%b valid=%b expected 1/0/0", bus.err, bus.imem_rd, bus.id_valid);
        end
        for (int c = 0; c < 5; c++) begin
            bus.id_stall = $urandom_range(1);
            bus.redirect = $urandom_range(1);
            bus.redirect_pc = 16'($urandom_range(100) * 2);
            @(negedge clk); #1;
            n_checks++; if (bus.err !== 1'b1 || bus.imem_rd !== 1'b0 || bus.id_valid !== 1'b0) begin
                n_fail++; $display("FAIL err_sticky: cycle %0d got err=%b rd=%b valid=%b expected 1/0/0", c, bus.err, bus.imem_rd, bus.id_valid);
            end
        end
        bus.redirect = 1'b0;
        do_reset();
        mem_lat = 0;
        repeat (4) begin @(negedge clk); #1; end
        mem_lat = 5;
        repeat (2) begin @(negedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.id_valid !== 1'b0 || bus.id_instr !== 16'h0800 || bus.id_pc_inc !== 16'h0000 || bus.imem_rd !== 1'b0 || bus.err !== 1'b0 || bus.halted !== 1'b0) begin
            n_fail++; $display("FAIL async_rst: got valid=%b instr=%h pc_inc=%h rd=%b err=%b halted=%b expected 0/0800/0000/0/0/0",
                               bus.id_valid, bus.id_instr, bus.id_pc_inc, bus.imem_rd, bus.err, bus.halted);
        end
        mem_lat = 0;
        @(posedge clk); #1 rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk); #1;
            if (bus.id_valid) seen = 1'b1;
        end
        n_checks++; if (!seen || bus.id_pc_inc !== 16'h0002 || bus.id_instr !== mem_word(16'h0000)) begin
            n_fail++; $display("FAIL async_restart: got seen=%b %h/%h expected %h/0002", seen, bus.id_instr, bus.id_pc_inc, mem_word(16'h0000));
        end
        $display("test_err_async_reset: misaligned redirect and mid-wait reset checked");
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        mem_lat = 0;
        bus.id_stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 16'h0000;
        fill_mem();
        test_reset();
        test_stall_skid();
        test_redirect();
        test_halt(1'b0);
        test_halt(1'b1);
        test_timeout();
        test_err_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
